instrument_decoder: RTL and testbench
=====================================

# instrument_decoder

Parametrised successor to the fixed three-instrument controller. It takes bytes from the UART receiver and decodes a one-hot channel ID in the low bits of each byte. For each channel it holds the latest note, generates per-channel periodic strum pulses, and clears notes whose sender has gone silent. A registered monitor port drives the board LEDs. It sits between `async_receiver` and the instrument actuator outputs, and replaces the hard-coded bass/drum/guitar decode.

## Interface
- `NUM_CH`, 3: number of instrument channels. Range 1..7.
- `DATA_W`, 8: received byte width. Note width is the localparam `NOTE_W = DATA_W - NUM_CH`.
- `STRUM_MASK`, 3'b101: bit i set means channel i produces strum pulses. Default has channel 0 (guitar) and channel 2 (bass) set and channel 1 (drum) clear.
- `STRUM_PERIOD`, 5_000_000: strum repeat period in cycles. Must be at least 2.
- `STRUM_HIGH`, 1_000_000: strum pulse width in cycles. Range 1..STRUM_PERIOD-1.
- `TIMEOUT`, 50_000_000: idle cycles before a channel's note is cleared. 0 disables the timeout.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `rx_valid`, in, 1: single-cycle byte strobe from the receiver.
- `rx_data`, in, DATA_W: received byte. Bits [NUM_CH-1:0] are the one-hot ID; bits [DATA_W-1:NUM_CH] are the note.
- `mon_sel`, in, NUM_CH: one-hot monitor channel select (buttons).
- `note`, out, NUM_CH*NOTE_W: held notes, one NOTE_W slice per channel; channel i occupies slice i.
- `strum`, out, NUM_CH: per-channel strum pulse.
- `active`, out, NUM_CH: 1 when the channel's note is nonzero.
- `stale`, out, NUM_CH: 1 when the channel was cleared by timeout.
- `err_cnt`, out, 8: saturating count of bytes with an invalid ID.
- `leds`, out, NOTE_W+1: monitor output. Bit NOTE_W is the strum bit; bits [NOTE_W-1:0] are the note.

## Operation
- Reset: all of `note`, `strum`, `active`, `stale`, `err_cnt`, `leds` and every internal counter go to 0. Reset has priority over all other events; asserting it mid-pulse or mid-timeout aborts immediately.
- Decode: on `rx_valid`, the channel i whose ID field equals the one-hot value `1<<i` loads the note field. Only that channel is touched.
- ID field of zero or multi-hot: no channel changes; `err_cnt` increments and saturates at 255.
- Load effects: writing a nonzero note sets `active[i]` and clears `stale[i]`. Writing zero clears `active[i]` and also clears `stale[i]`.
- Strum, channels with `STRUM_MASK` bit clear: `strum[i]` is held at 0.
- Strum, channels with `STRUM_MASK` bit set: a phase counter runs 0..STRUM_PERIOD-1 while the note is nonzero. `strum[i]` is 1 while phase < STRUM_HIGH.
  - Any load of a nonzero note restarts the phase at 0, including a rewrite of the same value (re-strum).
  - A zero note, or a timeout clear, forces `strum[i]` to 0 and the phase to 0.
- Timeout, when TIMEOUT > 0: a per-channel idle counter is zeroed by every load to that channel and increments each cycle while `active[i]` is set.
  - On the cycle the counter equals TIMEOUT-1 with no load to that channel: note goes to 0, `active` to 0, `stale` to 1, and strum stops.
  - A load and a timeout in the same cycle: the load wins.
- Monitor: if `mon_sel` is one-hot on channel k, `leds` = {`strum[k]`, note slice k}. For a zero or multi-hot `mon_sel`, `leds` = 0.

## Timing
- Byte accepted at edge t (`rx_valid` high in cycle t): `note`, `active`, `stale` and the first strum-high cycle are all visible in cycle t+1.
- Strum high in cycles t+1 .. t+STRUM_HIGH, then low until t+STRUM_PERIOD, then repeats.
- `leds` is registered: it lags `note`/`strum` by one cycle, giving total latency 2 from `rx_valid`.
- `err_cnt` updates in t+1.
- Timeout: with no further bytes after a load at t, the note reads 0 from cycle t+1+TIMEOUT.
- Back-to-back `rx_valid` every cycle is supported with no loss.

## Structure
- Package `instrument_pkg`: `ID_BASS`/`ID_DRUM`/`ID_GUITAR` channel index constants, the default STRUM_MASK, and the `note_t` width helper.
- Sub-module `strum_gen`, one instance per channel via generate. Inputs: clk, rst, `load`, `note_nz`, `clear`. Output: `strum`. Parameters: STRUM_PERIOD and STRUM_HIGH.
- Counter widths are `$clog2` of their terminal value.
- The idle counter and note register stay in the top level.

## Test plan
- Bench parameters: STRUM_PERIOD=8, STRUM_HIGH=3, TIMEOUT=20.
- Reset then idle: all outputs 0 for 50 cycles; no strum and no timeout.
- Byte 8'b10101_001 → `note[0]`=5'b10101 and `active[0]`=1 at t+1. Strum[0] high in t+1..t+3, low in t+4..t+8, high again at t+9. `leds` with `mon_sel`=001 reads 6'b1_10101 at t+2.
- Byte 8'b00110_010 (drum) → note slice 1 = 6, `strum[1]` stays 0. Then byte 8'b00000_010 → note slice 1 = 0, `active[1]`=0.
- Invalid IDs 8'hF8 and 8'h07, 300 times total → no note changes; `err_cnt` saturates at 255.
- Load channel 2 at t with no further bytes → note slice 2 = 0 and `stale[2]`=1 at t+21. A load of channel 2 issued on the expiring cycle keeps the note and leaves `stale` at 0.
- Re-send the same nonzero note mid-pulse → phase restarts and strum is high for 3 cycles from the reload. Assert `rst` mid-pulse → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/instrument_decoder_pkg.sv
// ============================================================================
// Module : instrument_pkg
// Brief  : Channel index constants, default strum mask and note width helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instrument_pkg;

    localparam int ID_GUITAR = 0;
    localparam int ID_DRUM   = 1;
    localparam int ID_BASS   = 2;

    // Guitar and bass strum, drum does not.
    localparam logic [2:0] DEFAULT_STRUM_MASK = 3'b101;

    function automatic int note_w_of(input int data_w, input int num_ch);
        return data_w - num_ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instrument_decoder_strum_gen.sv
// ============================================================================
// Module : strum_gen
// Brief  : Per-channel periodic strum pulse, restarted by every nonzero load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module strum_gen #(
    parameter int STRUM_PERIOD = 5_000_000,
    parameter int STRUM_HIGH   = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic note_nz,
    input  logic clear,
    output logic strum
);

    localparam int             c_PH_W = $clog2(STRUM_PERIOD);
    localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(STRUM_PERIOD - 1);
    localparam logic [c_PH_W-1:0] c_HIGH = c_PH_W'(STRUM_HIGH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_PH_W-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = note_nz ? S_RUN : S_IDLE;
        end else if (clear) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (load || clear) begin
            r_phase <= '0;
        end else if (r_state == S_RUN) begin
            r_phase <= (r_phase == c_LAST) ? '0 : r_phase + c_PH_W'(1);
        end
    end

    always_comb begin
        strum = (r_state == S_RUN) && (r_phase < c_HIGH);
    end

endmodule

`default_nettype wire

// File: rtl/instrument_decoder.sv
// ============================================================================
// Module : instrument_decoder
// Brief  : One-hot channel decode of received bytes into held notes, strum
//          pulses, idle timeout and a registered LED monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instrument_decoder
    import instrument_pkg::*;
#(
    parameter int                NUM_CH       = 3,
    parameter int                DATA_W       = 8,
    parameter logic [NUM_CH-1:0] STRUM_MASK   = NUM_CH'(DEFAULT_STRUM_MASK),
    parameter int                STRUM_PERIOD = 5_000_000,
    parameter int                STRUM_HIGH   = 1_000_000,
    parameter int                TIMEOUT      = 50_000_000,
    localparam int               NOTE_W       = note_w_of(DATA_W, NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic [NUM_CH-1:0]        mon_sel,
    output logic [NUM_CH*NOTE_W-1:0] note,
    output logic [NUM_CH-1:0]        strum,
    output logic [NUM_CH-1:0]        active,
    output logic [NUM_CH-1:0]        stale,
    output logic [7:0]               err_cnt,
    output logic [NOTE_W:0]          leds
);

    localparam int               c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [NUM_CH-1:0] w_id;
    logic [NOTE_W-1:0] w_note_in;
    logic              w_id_ok;
    logic [NUM_CH-1:0] w_load_vec;
    logic              w_mon_ok;
    logic [NOTE_W:0]   w_leds;
    logic [7:0]        r_err_cnt;
    logic [NOTE_W:0]   r_leds;

    assign w_id       = rx_data[NUM_CH-1:0];
    assign w_note_in  = rx_data[DATA_W-1:NUM_CH];
    assign w_id_ok    = (w_id != '0) && ((w_id & (w_id - NUM_CH'(1))) == '0);
    assign w_load_vec = (rx_valid && w_id_ok) ? w_id : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [NOTE_W-1:0] r_note;
        logic              r_stale;
        logic              w_load;
        logic              w_expire;

        assign w_load = w_load_vec[i];

        if (TIMEOUT > 0) begin : g_timeout
            logic [c_TO_W-1:0] r_idle;

            // A load on the expiring cycle suppresses the clear.
            assign w_expire = (|r_note) && (r_idle == c_TO_LAST) && !w_load;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_idle <= '0;
                end else if (w_load || w_expire) begin
                    r_idle <= '0;
                end else if (|r_note) begin
                    r_idle <= r_idle + c_TO_W'(1);
                end
            end
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_note  <= '0;
                r_stale <= 1'b0;
            end else if (w_load) begin
                r_note  <= w_note_in;
                r_stale <= 1'b0;
            end else if (w_expire) begin
                r_note  <= '0;
                r_stale <= 1'b1;
            end
        end

        assign note[i*NOTE_W +: NOTE_W] = r_note;
        assign active[i]                = |r_note;
        assign stale[i]                 = r_stale;

        if (STRUM_MASK[i]) begin : g_strum
            strum_gen #(
                .STRUM_PERIOD (STRUM_PERIOD),
                .STRUM_HIGH   (STRUM_HIGH)
            ) u_strum_gen (
                .clk     (clk),
                .rst     (rst),
                .load    (w_load),
                .note_nz (|w_note_in),
                .clear   (w_expire),
                .strum   (strum[i])
            );
        end else begin : g_no_strum
            assign strum[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (rx_valid && !w_id_ok && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign w_mon_ok = (mon_sel != '0) && ((mon_sel & (mon_sel - NUM_CH'(1))) == '0);

    always_comb begin
        w_leds = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_mon_ok && mon_sel[k]) begin
                w_leds = {strum[k], note[k*NOTE_W +: NOTE_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds;
        end
    end

    assign err_cnt = r_err_cnt;
    assign leds    = r_leds;

endmodule

`default_nettype wire

// File: tb/tb_instrument_decoder.sv
// ============================================================================
// Module : tb_instrument_decoder
// Brief  : Scoreboard-driven bench for instrument_decoder (period 8, high 3,
//          timeout 20).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instrument_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [2:0]  mon_sel;
    logic [14:0] note;
    logic [2:0]  strum;
    logic [2:0]  active;
    logic [2:0]  stale;
    logic [7:0]  err_cnt;
    logic [5:0]  leds;

    instrument_decoder #(
        .NUM_CH       (3),
        .DATA_W       (8),
        .STRUM_MASK   (3'b101),
        .STRUM_PERIOD (8),
        .STRUM_HIGH   (3),
        .TIMEOUT      (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mon_sel  (mon_sel),
        .note     (note),
        .strum    (strum),
        .active   (active),
        .stale    (stale),
        .err_cnt  (err_cnt),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [4:0] nt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [4:0] note_of(input int ch);
        return note[ch*5 +: 5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte for the coming cycle and records the expected load.
    task automatic drive(input logic [7:0] b);
        exp_t e;
        tick();
        rx_valid = 1'b1;
        rx_data  = b;
        if (b[2:0] == 3'b001 || b[2:0] == 3'b010 || b[2:0] == 3'b100) begin
            e.ch = (b[2:0] == 3'b001) ? 0 : ((b[2:0] == 3'b010) ? 1 : 2);
            e.nt = b[7:3];
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_exp(output int ch, output logic [4:0] nt);
        exp_t e;
        if (sb.size() == 0) begin
            ch = 0;
            nt = 5'bx;
        end else begin
            e  = sb.pop_front();
            ch = e.ch;
            nt = e.nt;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        mon_sel  = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            total++;
            if ({note, strum, active, stale, err_cnt, leds} !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: got note=%h strum=%b act=%b stale=%b err=%0d leds=%b want all 0",
                         c, note, strum, active, stale, err_cnt, leds);
            end
        end
    endtask

    task automatic test_guitar();
        int         ch;
        logic [4:0] nt;
        logic       exp_s;
        do_reset();
        mon_sel = 3'b001;
        drive(8'b10101_001);
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt || active[ch] !== 1'b1) begin
            bad++;
            $display("FAIL guitar_load: got note=%b act=%b want note=%b act=1", note_of(ch), active[ch], nt);
        end
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            exp_s = (k <= 3) || (k == 9);
            total++;
            if (strum[0] !== exp_s) begin
                bad++;
                $display("FAIL guitar_strum t+%0d: got %b want %b", k, strum[0], exp_s);
            end
            if (k == 2) begin
                total++;
                if (leds !== 6'b1_10101) begin
                    bad++;
                    $display("FAIL guitar_leds: got %b want 110101", leds);
                end
            end
        end
    endtask

    task automatic test_drum();
        int         ch;
        logic [4:0] nt;
        do_reset();
        drive(8'b00110_010);
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt || ch != 1 || active[1] !== 1'b1) begin
            bad++;
            $display("FAIL drum_load: got note=%b act=%b want note=%b act=1", note_of(1), active[1], nt);
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (strum[1] !== 1'b0) begin
                bad++;
                $display("FAIL drum_no_strum k=%0d: got %b want 0", k, strum[1]);
            end
            tick();
        end
        drive(8'b00000_010);
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt || active[1] !== 1'b0 || stale[1] !== 1'b0) begin
            bad++;
            $display("FAIL drum_zero: got note=%b act=%b stale=%b want note=%b act=0 stale=0",
                     note_of(1), active[1], stale[1], nt);
        end
    endtask

    task automatic test_invalid();
        int         ch;
        logic [4:0] nt;
        do_reset();
        drive(8'b00110_010);
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 1) ? 8'hF8 : 8'h07);
            if (i == 0) begin
                pop_exp(ch, nt);
                total++;
                if (note_of(ch) !== nt) begin
                    bad++;
                    $display("FAIL invalid_preload: got %b want %b", note_of(ch), nt);
                end
            end
            if (i == 15) begin
                total++;
                if (note_of(1) !== 5'd6 || note_of(0) !== 5'd0 || note_of(2) !== 5'd0 || err_cnt !== 8'd15) begin
                    bad++;
                    $display("FAIL invalid_mid: got note=%h err=%0d want note slice1=6 others 0 err=15", note, err_cnt);
                end
            end
        end
        idle();
        total++;
        if (err_cnt !== 8'd255) begin
            bad++;
            $display("FAIL invalid_sat: got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_timeout();
        int         ch;
        logic [4:0] nt;
        do_reset();
        drive(8'b01011_100);
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt || ch != 2) begin
            bad++;
            $display("FAIL timeout_load: got %b want %b", note_of(2), nt);
        end
        repeat (19) tick();
        total++;
        if (note_of(2) !== 5'b01011 || stale[2] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_before: got note=%b stale=%b want note=01011 stale=0", note_of(2), stale[2]);
        end
        tick();
        total++;
        if (note_of(2) !== 5'd0 || stale[2] !== 1'b1 || active[2] !== 1'b0 || strum[2] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: got note=%b stale=%b act=%b strum=%b want 0/1/0/0",
                     note_of(2), stale[2], active[2], strum[2]);
        end

        do_reset();
        drive(8'b01011_100);
        idle();
        pop_exp(ch, nt);
        repeat (18) tick();
        drive(8'b01011_100);
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt || stale[2] !== 1'b0 || active[2] !== 1'b1 || strum[2] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_load_wins: got note=%b stale=%b act=%b strum=%b want %b/0/1/1",
                     note_of(2), stale[2], active[2], strum[2], nt);
        end
    endtask

    task automatic test_restrum();
        int         ch;
        logic [4:0] nt;
        logic       exp_s;
        do_reset();
        mon_sel = 3'b001;
        drive(8'b10101_001);
        idle();
        pop_exp(ch, nt);
        tick();
        drive(8'b10101_001);
        idle();
        pop_exp(ch, nt);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            exp_s = (k <= 3);
            total++;
            if (strum[0] !== exp_s || note_of(0) !== nt) begin
                bad++;
                $display("FAIL restrum t+%0d: got strum=%b note=%b want strum=%b note=%b",
                         k, strum[0], note_of(0), exp_s, nt);
            end
        end

        drive(8'b10101_001);
        idle();
        pop_exp(ch, nt);
        tick();
        total++;
        if (leds !== 6'b1_10101) begin
            bad++;
            $display("FAIL rst_pre_leds: got %b want 110101", leds);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({note, strum, active, stale, err_cnt, leds} !== '0) begin
            bad++;
            $display("FAIL rst_mid_pulse: got note=%h strum=%b act=%b stale=%b err=%0d leds=%b want all 0",
                     note, strum, active, stale, err_cnt, leds);
        end
    endtask

    task automatic test_back_to_back();
        int         ch;
        logic [4:0] nt;
        logic [7:0] bytes [5];
        bytes[0] = 8'b00001_001;
        bytes[1] = 8'b00010_010;
        bytes[2] = 8'b00011_100;
        bytes[3] = 8'b00100_001;
        bytes[4] = 8'b00101_010;
        do_reset();
        mon_sel = 3'b010;
        for (int i = 0; i < 5; i++) begin
            drive(bytes[i]);
            if (i > 0) begin
                pop_exp(ch, nt);
                total++;
                if (note_of(ch) !== nt) begin
                    bad++;
                    $display("FAIL b2b byte%0d: got %b want %b on ch%0d", i - 1, note_of(ch), nt, ch);
                end
            end
        end
        idle();
        pop_exp(ch, nt);
        total++;
        if (note_of(ch) !== nt) begin
            bad++;
            $display("FAIL b2b byte4: got %b want %b on ch%0d", note_of(ch), nt, ch);
        end
        tick();
        total++;
        if (leds !== 6'b0_00101) begin
            bad++;
            $display("FAIL mon_drum: got %b want 000101", leds);
        end
        mon_sel = 3'b011;
        tick();
        total++;
        if (leds !== 6'd0) begin
            bad++;
            $display("FAIL mon_multihot: got %b want 000000", leds);
        end
        mon_sel = 3'b000;
        tick();
        total++;
        if (leds !== 6'd0) begin
            bad++;
            $display("FAIL mon_zero: got %b want 000000", leds);
        end
        mon_sel = 3'b001;
        tick();
        total++;
        if (leds[4:0] !== 5'b00100) begin
            bad++;
            $display("FAIL mon_guitar: got %b want x00100", leds);
        end
    endtask

    initial begin
        test_reset();
        test_guitar();
        test_drum();
        test_invalid();
        test_timeout();
        test_restrum();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
